ffe_coef_ctrl: RTL

//  Owns the FFE tap coefficients for the 4-lane base-T TX encoder.

---
 rtl/ffe_ctrl_pkg.sv | 26 ++
 rtl/ffe_coef_bank.sv | 69 ++++++
 rtl/ffe_coef_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ffe_ctrl_pkg.sv
// Shared types and sizing helpers for the FFE coefficient controller.
// The coefficient bank and the commit FSM both import this package.
package ffe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_QUIET,
        SWAP,
        ABORT,
        DONE
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // A coefficient of exactly 1.0 in Q1.(coef_w-2)
    function automatic int unity_coef(input int coef_w);
        return 1 << (coef_w - 2);
    endfunction

endpackage

// File: rtl/ffe_coef_bank.sv
// LANES x TAPS coefficient register array: resets to an identity filter,
// takes single-tap writes, and can bulk-load every tap at once.
module ffe_coef_bank
    import ffe_ctrl_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int TAPS   = 4,
    parameter int COEF_W = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [idx_w(LANES)-1:0]        wr_lane,
    input  logic [idx_w(TAPS)-1:0]         wr_tap,
    input  logic signed [COEF_W-1:0]       wr_data,
    input  logic                           load_en,
    input  logic [LANES*TAPS*COEF_W-1:0]   load_data,
    output logic [LANES*TAPS*COEF_W-1:0]   taps
);

    localparam int LW = idx_w(LANES);
    localparam int TW = idx_w(TAPS);
    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(unity_coef(COEF_W));

    logic signed [COEF_W-1:0] mem [LANES][TAPS];
    logic                     lane_ok;
    logic                     tap_ok;

    // Index ranges only need guarding when the counts are not powers of two
    if (LANES == (1 << LW)) begin : g_lane_full
        assign lane_ok = 1'b1;
    end else begin : g_lane_part
        assign lane_ok = (32'(wr_lane) < LANES);
    end

    if (TAPS == (1 << TW)) begin : g_tap_full
        assign tap_ok = 1'b1;
    end else begin : g_tap_part
        assign tap_ok = (32'(wr_tap) < TAPS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int l = 0; l < LANES; l++) begin
                for (int t = 0; t < TAPS; t++) begin
                    mem[l][t] <= (t == 0) ? UNITY : '0;
                end
            end
        end else if (load_en) begin
            for (int l = 0; l < LANES; l++) begin
                for (int t = 0; t < TAPS; t++) begin
                    mem[l][t] <= load_data[(l*TAPS+t)*COEF_W +: COEF_W];
                end
            end
        end else if (wr_en && lane_ok && tap_ok) begin
            mem[wr_lane][wr_tap] <= wr_data;
        end
    end

    always_comb begin
        taps = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int t = 0; t < TAPS; t++) begin
                taps[(l*TAPS+t)*COEF_W +: COEF_W] = mem[l][t];
            end
        end
    end

endmodule

// File: rtl/ffe_coef_ctrl.sv
// FFE tap coefficient controller: shadow bank loaded by software, copied to the
// active bank once the FFE input has been quiet long enough (or on a forced commit).
module ffe_coef_ctrl
    import ffe_ctrl_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int TAPS         = 4,
    parameter int COEF_W       = 8,
    parameter int IDLE_CYCLES  = 4,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           io_cfg_valid,
    output logic                           io_cfg_ready,
    input  logic [idx_w(LANES)-1:0]        io_cfg_lane,
    input  logic [idx_w(TAPS)-1:0]         io_cfg_tap,
    input  logic signed [COEF_W-1:0]       io_cfg_data,
    input  logic                           io_commit_valid,
    output logic                           io_commit_ready,
    input  logic                           io_commit_force,
    input  logic                           io_data_valid,
    output logic [LANES*TAPS*COEF_W-1:0]   io_taps,
    output logic                           io_busy,
    output logic                           io_commit_done,
    output logic                           io_commit_abort
);

    localparam int QW = cnt_w(IDLE_CYCLES);
    localparam int WW = cnt_w(WAIT_TIMEOUT);
    localparam logic [QW-1:0] QUIET_MAX = QW'(IDLE_CYCLES);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(WAIT_TIMEOUT);

    state_e                         state;
    logic [QW-1:0]                  quiet_cnt;
    logic [WW-1:0]                  wait_cnt;
    logic                           force_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           abort_q;
    logic                           cfg_fire;
    logic                           commit_fire;
    logic                           swap_en;
    logic [LANES*TAPS*COEF_W-1:0]   shadow_taps;

    assign io_cfg_ready    = ~busy_q;
    assign io_commit_ready = ~busy_q;
    assign io_busy         = busy_q;
    assign io_commit_done  = done_q;
    assign io_commit_abort = abort_q;

    assign cfg_fire    = io_cfg_valid && io_cfg_ready;
    assign commit_fire = io_commit_valid && io_commit_ready;
    assign swap_en     = (state == SWAP);

    ffe_coef_bank #(
        .LANES  (LANES),
        .TAPS   (TAPS),
        .COEF_W (COEF_W)
    ) u_shadow (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (cfg_fire),
        .wr_lane   (io_cfg_lane),
        .wr_tap    (io_cfg_tap),
        .wr_data   (io_cfg_data),
        .load_en   (1'b0),
        .load_data ('0),
        .taps      (shadow_taps)
    );

    ffe_coef_bank #(
        .LANES  (LANES),
        .TAPS   (TAPS),
        .COEF_W (COEF_W)
    ) u_active (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (1'b0),
        .wr_lane   ('0),
        .wr_tap    ('0),
        .wr_data   ('0),
        .load_en   (swap_en),
        .load_data (shadow_taps),
        .taps      (io_taps)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            quiet_cnt <= '0;
            wait_cnt  <= '0;
            force_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            // Quiet tracking runs in every state so a late commit can swap at once
            if (io_data_valid) begin
                quiet_cnt <= '0;
            end else if (quiet_cnt != QUIET_MAX) begin
                quiet_cnt <= quiet_cnt + QW'(1);
            end

            done_q  <= 1'b0;
            abort_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (commit_fire) begin
                        state    <= WAIT_QUIET;
                        busy_q   <= 1'b1;
                        force_q  <= io_commit_force;
                        wait_cnt <= '0;
                    end
                end
                WAIT_QUIET: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    if (force_q || (quiet_cnt >= QUIET_MAX)) begin
                        state <= SWAP;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state   <= ABORT;
                        abort_q <= 1'b1;
                    end
                end
                SWAP: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                ABORT: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
